// File: rtl/edge_window_filter.sv
// 3x3 Sobel edge stage: two line buffers, a 3x3 window and a three-stage gradient/threshold pipeline.
// Define EDGE_FILTER_OVERLAY_EN to paint detected edges black on oPix; otherwise oPix mirrors oY.
module edge_window_filter #(
  parameter int PIX_W    = 10,
  parameter int LINE_LEN = 640,
  parameter int X_W      = 10
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iDVAL,
  input  logic             iSOF,
  input  logic [PIX_W-1:0] iY,
  input  logic [1:0]       iMode,
  input  logic [PIX_W+3:0] iThreshold,
  output logic             oDVAL,
  output logic [X_W-1:0]   oX,
  output logic [PIX_W-1:0] oY,
  output logic [PIX_W+3:0] oMag,
  output logic             oEdge,
  output logic [PIX_W-1:0] oPix
);

  localparam int G_W = PIX_W + 3;
  localparam logic [X_W-1:0] X_LAST = X_W'(LINE_LEN - 1);

  typedef enum logic [1:0] {
    MODE_GY  = 2'd0,
    MODE_GX  = 2'd1,
    MODE_ANY = 2'd2,
    MODE_MAG = 2'd3
  } mode_e;

  // Position of the pixel presented this cycle; iSOF forces it to (0,0).
  logic [X_W-1:0] r_x;
  logic [1:0]     r_ln;
  logic [X_W-1:0] w_px;
  logic [1:0]     w_pln;

  assign w_px  = iSOF ? '0 : r_x;
  assign w_pln = iSOF ? 2'd0 : r_ln;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_x  <= '0;
      r_ln <= '0;
    end else if (iDVAL) begin
      if (w_px == X_LAST) begin
        r_x  <= '0;
        r_ln <= (w_pln == 2'd2) ? 2'd2 : w_pln + 2'd1;
      end else begin
        r_x  <= w_px + X_W'(1);
        r_ln <= w_pln;
      end
    end else if (iSOF) begin
      r_x  <= '0;
      r_ln <= '0;
    end
  end

  logic [PIX_W-1:0] r_lb1 [LINE_LEN];
  logic [PIX_W-1:0] r_lb2 [LINE_LEN];
  logic [PIX_W-1:0] w_lb1_rd;
  logic [PIX_W-1:0] w_lb2_rd;

  assign w_lb1_rd = r_lb1[w_px];
  assign w_lb2_rd = r_lb2[w_px];

  // NOTE: the line buffers have no reset; stale words only ever reach border-suppressed windows.
  always_ff @(posedge iCLK) begin
    if (iDVAL) begin
      r_lb1[w_px] <= iY;
      r_lb2[w_px] <= w_lb1_rd;
    end
  end

  // Stage 0: window rows, index 2 is the newest (right) column.
  logic [PIX_W-1:0] r_t [3];
  logic [PIX_W-1:0] r_m [3];
  logic [PIX_W-1:0] r_b [3];
  logic             r_s0_v;
  logic [X_W-1:0]   r_s0_x;
  logic [1:0]       r_s0_ln;

  always_ff @(posedge iCLK) begin
    if (iDVAL) begin
      r_t[0]  <= r_t[1];
      r_t[1]  <= r_t[2];
      r_t[2]  <= w_lb2_rd;
      r_m[0]  <= r_m[1];
      r_m[1]  <= r_m[2];
      r_m[2]  <= w_lb1_rd;
      r_b[0]  <= r_b[1];
      r_b[1]  <= r_b[2];
      r_b[2]  <= iY;
      r_s0_x  <= w_px;
      r_s0_ln <= w_pln;
    end
  end

  function automatic logic signed [G_W-1:0] sx(input logic [PIX_W-1:0] p);
    return $signed({3'b000, p});
  endfunction

  logic signed [G_W-1:0] w_gx;
  logic signed [G_W-1:0] w_gy;
  logic [X_W-1:0]        w_cx;

  assign w_gx = (sx(r_t[2]) + (sx(r_m[2]) <<< 1) + sx(r_b[2]))
              - (sx(r_t[0]) + (sx(r_m[0]) <<< 1) + sx(r_b[0]));
  assign w_gy = (sx(r_b[0]) + (sx(r_b[1]) <<< 1) + sx(r_b[2]))
              - (sx(r_t[0]) + (sx(r_t[1]) <<< 1) + sx(r_t[2]));
  assign w_cx = (r_s0_x == '0) ? X_LAST : r_s0_x - X_W'(1);

  // Stage 1: registered gradients plus the centre pixel and its border flag.
  logic                  r_s1_v;
  logic signed [G_W-1:0] r_s1_gx;
  logic signed [G_W-1:0] r_s1_gy;
  logic [X_W-1:0]        r_s1_x;
  logic [PIX_W-1:0]      r_s1_y;
  logic                  r_s1_sup;

  always_ff @(posedge iCLK) begin
    if (r_s0_v) begin
      r_s1_gx  <= w_gx;
      r_s1_gy  <= w_gy;
      r_s1_x   <= w_cx;
      r_s1_y   <= r_m[1];
      r_s1_sup <= (r_s0_x < X_W'(2)) || (r_s0_ln != 2'd2);
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_s0_v <= 1'b0;
      r_s1_v <= 1'b0;
    end else begin
      r_s0_v <= iDVAL;
      r_s1_v <= r_s0_v;
    end
  end

  // Stage 2: magnitudes and threshold decision against the live mode/threshold.
  logic [G_W-1:0]   w_ax;
  logic [G_W-1:0]   w_ay;
  logic [PIX_W+3:0] w_mag;
  logic             w_hit;
  logic             w_edge;

  assign w_ax  = r_s1_gx[G_W-1] ? $unsigned(-r_s1_gx) : $unsigned(r_s1_gx);
  assign w_ay  = r_s1_gy[G_W-1] ? $unsigned(-r_s1_gy) : $unsigned(r_s1_gy);
  assign w_mag = {1'b0, w_ax} + {1'b0, w_ay};

  // NOTE: assigning a default first keeps this block from inferring a latch.
  always_comb begin
    w_hit = 1'b0;
    case (mode_e'(iMode))
      MODE_GY:  w_hit = {1'b0, w_ay} > iThreshold;
      MODE_GX:  w_hit = {1'b0, w_ax} > iThreshold;
      MODE_ANY: w_hit = ({1'b0, w_ay} > iThreshold) || ({1'b0, w_ax} > iThreshold);
      MODE_MAG: w_hit = w_mag > iThreshold;
      default:  w_hit = 1'b0;
    endcase
  end

  assign w_edge = w_hit && !r_s1_sup;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      oDVAL <= 1'b0;
      oX    <= '0;
      oY    <= '0;
      oMag  <= '0;
      oEdge <= 1'b0;
    end else begin
      oDVAL <= r_s1_v;
      if (r_s1_v) begin
        oX    <= r_s1_x;
        oY    <= r_s1_y;
        oMag  <= w_mag;
        oEdge <= w_edge;
      end
    end
  end

`ifdef EDGE_FILTER_OVERLAY_EN
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      oPix <= '0;
    end else if (r_s1_v) begin
      oPix <= w_edge ? '0 : r_s1_y;
    end
  end
`else
  assign oPix = oY;
`endif

endmodule

// File: tb/tb_edge_window_filter.sv
// Scoreboard bench for edge_window_filter: directed images, expected results queued at issue time.
module tb_edge_window_filter;

  localparam int PIX_W    = 10;
  localparam int LINE_LEN = 640;
  localparam int X_W      = 10;

  logic             iCLK;
  logic             iRST;
  logic             iDVAL;
  logic             iSOF;
  logic [PIX_W-1:0] iY;
  logic [1:0]       iMode;
  logic [PIX_W+3:0] iThreshold;
  logic             oDVAL;
  logic [X_W-1:0]   oX;
  logic [PIX_W-1:0] oY;
  logic [PIX_W+3:0] oMag;
  logic             oEdge;
  logic [PIX_W-1:0] oPix;

  edge_window_filter #(.PIX_W(PIX_W), .LINE_LEN(LINE_LEN), .X_W(X_W)) dut (
    .iCLK(iCLK), .iRST(iRST), .iDVAL(iDVAL), .iSOF(iSOF), .iY(iY),
    .iMode(iMode), .iThreshold(iThreshold),
    .oDVAL(oDVAL), .oX(oX), .oY(oY), .oMag(oMag), .oEdge(oEdge), .oPix(oPix)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  typedef struct {
    int x;
    int y;
    int ax;
    int ay;
    bit border;
    int issue;
  } exp_t;

  exp_t sb[$];
  int   n_err = 0;
  int   n_checks = 0;
  int   cyc = 0;
  int   edge_cnt = 0;
  int   last_x = 0;
  int   m_x = 0;
  int   m_row = 0;
  int   img [4][LINE_LEN];
  int   mode_h [16];
  int   thr_h [16];

  always @(posedge iCLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, expv);
    end
  endtask

  function automatic int gp(input int r, input int c);
    return img[r % 4][c];
  endfunction

  // Reference: absolute row/column image, Sobel straight from the formulas.
  task automatic model(input logic dval, input logic sof, input int y);
    exp_t e;
    int gx;
    int gy;
    if (sof) begin
      m_x   = 0;
      m_row = 0;
    end
    if (dval) begin
      img[m_row % 4][m_x] = y;
      e.x      = (m_x == 0) ? LINE_LEN - 1 : m_x - 1;
      e.border = (m_x < 2) || (m_row < 2);
      e.y  = 0;
      e.ax = 0;
      e.ay = 0;
      if (!e.border) begin
        e.y = gp(m_row - 1, m_x - 1);
        gx = (gp(m_row - 2, m_x) + 2 * gp(m_row - 1, m_x) + gp(m_row, m_x))
           - (gp(m_row - 2, m_x - 2) + 2 * gp(m_row - 1, m_x - 2) + gp(m_row, m_x - 2));
        gy = (gp(m_row, m_x - 2) + 2 * gp(m_row, m_x - 1) + gp(m_row, m_x))
           - (gp(m_row - 2, m_x - 2) + 2 * gp(m_row - 2, m_x - 1) + gp(m_row - 2, m_x));
        e.ax = (gx < 0) ? -gx : gx;
        e.ay = (gy < 0) ? -gy : gy;
      end
      e.issue = cyc;
      sb.push_back(e);
      if (m_x == LINE_LEN - 1) begin
        m_x = 0;
        m_row++;
      end else begin
        m_x++;
      end
    end
  endtask

  task automatic pix(input logic dval, input logic sof, input int y);
    iDVAL = dval;
    iSOF  = sof;
    iY    = PIX_W'(y);
    model(dval, sof, y);
    @(posedge iCLK);
    #1;
  endtask

  task automatic idle(input int n);
    iDVAL = 1'b0;
    iSOF  = 1'b0;
    repeat (n) begin
      @(posedge iCLK);
      #1;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    iDVAL = 1'b0;
    iSOF  = 1'b0;
    while (sb.size() != 0 && n < 10) begin
      @(posedge iCLK);
      #1;
      n++;
    end
    check("drain_queue_empty", sb.size(), 0);
    idle(2);
  endtask

  function automatic int img_px(input int kind, input int r, input int c);
    case (kind)
      0:       return 100;
      1:       return (c < 320) ? 0 : 1023;
      2:       return (r < 10) ? 0 : 1023;
      default: return $urandom_range(0, 1023);
    endcase
  endfunction

  task automatic frame(input int kind, input int rows, input bit sof_first);
    for (int r = 0; r < rows; r++)
      for (int c = 0; c < LINE_LEN; c++)
        pix(1'b1, sof_first && r == 0 && c == 0, img_px(kind, r, c));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_dval"}, oDVAL, 0);
    check({tag, "_x"}, oX, 0);
    check({tag, "_y"}, oY, 0);
    check({tag, "_mag"}, oMag, 0);
    check({tag, "_edge"}, oEdge, 0);
    check({tag, "_pix"}, oPix, 0);
  endtask

  // Monitor: compares the queue head when its strobe is due, else expects quiet held outputs.
  always @(negedge iCLK) begin
    exp_t e;
    int   md;
    int   th;
    logic exp_edge;
    mode_h[cyc % 16] = int'(iMode);
    thr_h[cyc % 16]  = int'(iThreshold);
    if (iRST) begin
      last_x = 0;
    end else if (sb.size() != 0 && sb[0].issue + 3 == cyc) begin
      e = sb.pop_front();
      check("dval", oDVAL, 1);
      check("x", oX, e.x);
      last_x = e.x;
      if (e.border) begin
        check("border_edge", oEdge, 0);
      end else begin
        md = mode_h[(e.issue + 2) % 16];
        th = thr_h[(e.issue + 2) % 16];
        case (md)
          0:       exp_edge = e.ay > th;
          1:       exp_edge = e.ax > th;
          2:       exp_edge = (e.ay > th) || (e.ax > th);
          default: exp_edge = (e.ax + e.ay) > th;
        endcase
        check("y", oY, e.y);
        check("mag", oMag, e.ax + e.ay);
        check("edge", oEdge, exp_edge);
`ifdef EDGE_FILTER_OVERLAY_EN
        check("pix", oPix, exp_edge ? 0 : e.y);
`else
        check("pix", oPix, e.y);
`endif
      end
      if (oDVAL && oEdge) edge_cnt++;
    end else begin
      check("dval_idle", oDVAL, 0);
      check("hold_x", oX, last_x);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt0;
    iRST = 1'b1;
    iDVAL = 1'b0;
    iSOF = 1'b0;
    iY = '0;
    iMode = 2'd3;
    iThreshold = '0;
    repeat (3) @(posedge iCLK);
    #1;
    check_reset_outputs("rst_init");
    iRST = 1'b0;
    idle(3);

    // Reset mid-stream: in-flight results vanish, next pixel restarts at (0,0).
    for (int i = 0; i < 20; i++) pix(1'b1, i == 0, (i * 37) % 1024);
    iDVAL = 1'b0;
    iRST  = 1'b1;
    sb.delete();
    #1;
    check_reset_outputs("rst_mid");
    repeat (2) begin
      @(posedge iCLK);
      #1;
    end
    iRST  = 1'b0;
    m_x   = 0;
    m_row = 0;
    idle(4);

    // Flat field, no iSOF: first post-reset pixel is (0,0).
    iMode = 2'd3;
    iThreshold = 14'd0;
    cnt0 = edge_cnt;
    frame(0, 3, 1'b0);
    drain();
    check("flat_edge_count", edge_cnt - cnt0, 0);

    // Vertical step: edges centred on columns 319 and 320 of rows 1 and 2.
    iMode = 2'd1;
    iThreshold = 14'd512;
    cnt0 = edge_cnt;
    frame(1, 4, 1'b1);
    drain();
    check("vstep_gx_edge_count", edge_cnt - cnt0, 4);
    iMode = 2'd0;
    cnt0 = edge_cnt;
    frame(1, 4, 1'b1);
    drain();
    check("vstep_gy_edge_count", edge_cnt - cnt0, 0);

    // Horizontal step: rows centred on 9 and 10, columns 1..638.
    iMode = 2'd0;
    iThreshold = 14'd512;
    cnt0 = edge_cnt;
    frame(2, 12, 1'b1);
    drain();
    check("hstep_edge_count", edge_cnt - cnt0, 2 * (LINE_LEN - 2));

    // Random image, iSOF alone first, then iSOF re-asserted at x=100 of line 3.
    iMode = 2'd3;
    iThreshold = 14'd0;
    pix(1'b0, 1'b1, 0);
    for (int p = 0; p < 3 * LINE_LEN + 100; p++) pix(1'b1, 1'b0, $urandom_range(0, 1023));
    for (int p = 0; p < 3 * LINE_LEN; p++) pix(1'b1, p == 0, $urandom_range(0, 1023));
    drain();

    // Gapped input at 1/3 duty, mode switched 2 -> 3 mid-line.
    iMode = 2'd2;
    iThreshold = 14'd1500;
    for (int p = 0; p < 3 * LINE_LEN; p++) begin
      if (p == 2 * LINE_LEN + 320) iMode = 2'd3;
      pix(1'b1, p == 0, $urandom_range(0, 1023));
      pix(1'b0, 1'b0, 0);
      pix(1'b0, 1'b0, 0);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/edge_window_filter.md
# edge_window_filter

Parametrised 3x3 Sobel edge-detection stage for the live-video path. It accepts one intensity pixel per `iDVAL` strobe in raster order. It holds two internal line buffers and a 3x3 window, and computes the horizontal and vertical gradients. It emits a per-pixel edge flag, the gradient magnitude and the delayed centre pixel. It replaces the fixed 640-pixel, OR-only horizontal/vertical detector pair, adding width/line-length generics, a runtime mode, a runtime threshold, and frame-border suppression.

## Interface
- `PIX_W`, 10, intensity width in bits.
- `LINE_LEN`, 640, active pixels per line (must be >= 3).
- `X_W`, 10, column counter width; must satisfy 2^X_W >= LINE_LEN.
- `iCLK`  in  1  pixel clock; all logic is on its rising edge.
- `iRST`  in  1  reset, asynchronous, active-high.
- `iDVAL`  in  1  input pixel strobe.
- `iSOF`  in  1  start of frame; the pixel on this cycle is (0,0).
- `iY`  in  PIX_W  input intensity.
- `iMode`  in  2  0 = horizontal edges (Gy), 1 = vertical edges (Gx), 2 = either, 3 = magnitude.
- `iThreshold`  in  PIX_W+4  edge threshold, unsigned.
- `oDVAL`  out  1  result strobe.
- `oX`  out  X_W  column of the result centre pixel.
- `oY`  out  PIX_W  centre pixel intensity.
- `oMag`  out  PIX_W+4  |Gx|+|Gy|.
- `oEdge`  out  1  edge flag.
- `oPix`  out  PIX_W  display pixel (see Configuration).

## Operation
- **Column and line counters.**
  - An accepted pixel (`iDVAL`=1) advances column counter `x`, wrapping LINE_LEN-1 -> 0.
  - On wrap, line counter `ln` increments and saturates at 2.
  - `iSOF`=1 forces the pixel on that cycle to x=0, ln=0, whether or not `iDVAL` is high.
  - `iSOF` without `iDVAL` only clears the counters.
- **Line buffers.**
  - Two LINE_LEN-deep buffers, read and written at address `x` on accepted pixels only.
  - Buffer 1 receives `iY`; buffer 2 receives buffer 1's old word.
  - Contents are not cleared by reset or `iSOF`.
- **Window.**
  - Three 3-tap shift rows (top = buffer 2, mid = buffer 1, bottom = `iY`).
  - Rows shift on accepted pixels only.
  - The centre is column x-1, row ln-1.
- **Gradients.**
  - Gx = (TR+2MR+BR) - (TL+2ML+BL).
  - Gy = (BL+2BM+BR) - (TL+2TM+TR).
  - Both signed, PIX_W+3 bits; no overflow is possible.
  - Magnitude = |Gx|+|Gy|, unsigned PIX_W+4 bits.
- **Edge decision.** Comparisons are strictly greater than `iThreshold`.
  - Mode 0: |Gy| > T.
  - Mode 1: |Gx| > T.
  - Mode 2: either of modes 0 and 1.
  - Mode 3: magnitude > T.
- **Border suppression.** `oEdge` is forced 0 when the window's right column x < 2 or ln < 2 (partial window). `oMag` still reports the computed value.
- **Runtime inputs.** `iMode` and `iThreshold` are sampled in stage 2 and may change at any time. The new value applies to results leaving stage 2 on the next cycle.

## Timing
- **Pipeline.**
  - Stage 0: buffer read and window shift.
  - Stage 1: Gx and Gy registered.
  - Stage 2: absolute values, sum, compare, outputs registered.
- **Latency.** A pixel accepted at cycle t produces `oDVAL`=1 at t+3, for the window whose right column is that pixel.
- **Strobe behaviour.** `oDVAL` is a one-cycle pulse per accepted pixel, with no back-pressure. Gaps in `iDVAL` propagate unchanged.
- **Output hold.** All data outputs hold their value between strobes.
- **Reset values.** While `iRST` is high, all outputs, counters and pipeline valid bits are 0. Deassertion takes effect at the next `iCLK` edge.
- **Reset mid-frame.**
  - In-flight results are discarded, with no `oDVAL`.
  - The first accepted pixel after reset is treated as (0,0) of a new frame.
- **`iSOF` mid-line.** Results already in the pipeline still complete. New results carry border suppression until ln reaches 2.

## Configuration
- Macro `EDGE_FILTER_OVERLAY_EN`.
- When defined: `oPix` = 0 when `oEdge`=1, otherwise the centre pixel (black edge over grayscale).
- When undefined: `oPix` equals `oY` and the overlay mux is not built.
- All other behaviour is identical in both builds.

## Test plan
1. **Reset.** Assert `iRST` mid-stream -> all outputs 0 within the same cycle; no `oDVAL` until 3 cycles after the first post-reset `iDVAL`.
2. **Flat field.** Constant `iY`=100, mode 3, T=0 -> `oMag`=0 and `oEdge`=0 for every pixel.
3. **Vertical step.** Columns < 320 = 0, columns >= 320 = 1023; mode 1, T=512; lines >= 2.
   - `oEdge`=1 exactly at `oX`=319 and 320, with `oMag`=4092.
   - Mode 0 gives no edges.
4. **Horizontal step.** Lines 0-9 = 0, lines >= 10 = 1023; mode 0 -> `oEdge`=1 for the rows centred on lines 9 and 10, columns 1 to LINE_LEN-2.
5. **Border and `iSOF`.**
   - Random image; `oEdge`=0 for the first 2 lines and whenever the window's right column is < 2.
   - Re-assert `iSOF` at x=100 -> suppression restarts.
6. **Gapped input.** `iDVAL` duty 1/3 and `iMode` switched 2->3 mid-line -> results match a reference model pixel for pixel, each at fixed latency 3 from its strobe. With `EDGE_FILTER_OVERLAY_EN`, `oPix`=0 exactly where `oEdge`=1.
